// File: rtl/dccm_port_arb.sv
// ============================================================================
// Module      : dccm_port_arb
// Description : Arbiter/sequencer for the single DCCM access port shared by
//               the LSU and the DMA slave. Grants at most one requester per
//               cycle, drives the DCCM read/write controls and turns
//               partial-word writes into a two-cycle read-modify-write.
//               Optional DMA anti-starvation priority is enabled by defining
//               the macro RV_DCCM_ARB_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dccm_port_arb #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_l,

    input  logic              lsu_req,
    input  logic              lsu_wr,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    input  logic [3:0]        lsu_byteen,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [31:0]       lsu_rdata,

    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_byteen,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,

    output logic              dccm_rden,
    output logic [ADDR_W-1:0] dccm_rd_addr_lo,
    output logic              dccm_wren,
    output logic [ADDR_W-1:0] dccm_wr_addr,
    output logic [31:0]       dccm_wr_data,
    input  logic [31:0]       dccm_rd_data_lo,

    output logic              arb_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   rmw_addr_q;
    logic [31:0]         rmw_wdata_q;
    logic [3:0]          rmw_byteen_q;

    logic                lsu_rvalid_q;
    logic                dma_rvalid_q;
    logic [31:0]         lsu_rdata_q;
    logic [31:0]         dma_rdata_q;

    // Word-aligned request addresses; the two low address bits carry no
    // meaning on this 32-bit port.
    logic [ADDR_W-1:0]   w_lsu_addr_al;
    logic [ADDR_W-1:0]   w_dma_addr_al;
    logic                w_unused_addr_lo;

    assign w_lsu_addr_al    = {lsu_addr[ADDR_W-1:2], 2'b00};
    assign w_dma_addr_al    = {dma_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_addr_lo = ^{lsu_addr[1:0], dma_addr[1:0]};

    // Arbitration qualifiers. Everything combinational is forced low while
    // reset is asserted so that an in-flight RMW write is dropped at once.
    logic w_idle;
    logic w_rmw;
    logic w_dma_pri;

    assign w_idle = rst_l & (state_q == ST_IDLE);
    assign w_rmw  = rst_l & (state_q == ST_RMW);

`ifdef RV_DCCM_ARB_STARVE_EN
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    // DMA is promoted once it has lost arbitration STARVE_MAX times in a row.
    assign w_dma_pri = (starve_cnt_q >= c_starve_max);

    // Count IDLE cycles in which DMA waits; RMW cycles hold the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dma_req || dma_gnt) begin
            starve_cnt_d = 4'd0;
        end else if ((state_q == ST_IDLE) && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict LSU priority: DMA only wins when the LSU is not requesting.
    logic w_unused_starve_max;

    assign w_dma_pri           = 1'b0;
    assign w_unused_starve_max = (STARVE_MAX != 0);
`endif

    // Winner selection and the selected request's attributes.
    logic              w_lsu_win;
    logic              w_dma_win;
    logic              w_any_win;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_byteen;
    logic              w_sel_rd;
    logic              w_sel_full;
    logic              w_sel_part;

    assign w_lsu_win    = w_idle & lsu_req & ~(dma_req & w_dma_pri);
    assign w_dma_win    = w_idle & dma_req & ~w_lsu_win;
    assign w_any_win    = w_lsu_win | w_dma_win;

    assign w_sel_wr     = w_lsu_win ? lsu_wr        : dma_wr;
    assign w_sel_addr   = w_lsu_win ? w_lsu_addr_al : w_dma_addr_al;
    assign w_sel_wdata  = w_lsu_win ? lsu_wdata     : dma_wdata;
    assign w_sel_byteen = w_lsu_win ? lsu_byteen    : dma_byteen;

    // An all-zero byte enable is accepted but touches nothing in the DCCM.
    assign w_sel_rd   = w_any_win & ~w_sel_wr;
    assign w_sel_full = w_any_win &  w_sel_wr & (w_sel_byteen == 4'hF);
    assign w_sel_part = w_any_win &  w_sel_wr & (w_sel_byteen != 4'hF)
                                              & (w_sel_byteen != 4'h0);

    assign lsu_gnt = w_lsu_win;
    assign dma_gnt = w_dma_win;

    // Byte merge for the second half of a read-modify-write: enabled bytes
    // come from the captured write data, the rest from the old word.
    logic [31:0] w_merge_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign w_merge_data[8*gi +: 8] = rmw_byteen_q[gi] ? rmw_wdata_q[8*gi +: 8]
                                                          : dccm_rd_data_lo[8*gi +: 8];
    end

    // DCCM port drive. A read (plain or RMW first half) and a write never
    // coincide: writes only issue for full-word grants or in the RMW state,
    // neither of which can raise the read enable.
    assign dccm_rden       = w_sel_rd | w_sel_part;
    assign dccm_rd_addr_lo = dccm_rden ? w_sel_addr : '0;

    assign dccm_wren       = w_sel_full | w_rmw;
    assign dccm_wr_addr    = w_rmw      ? rmw_addr_q
                           : w_sel_full ? w_sel_addr
                           : '0;
    assign dccm_wr_data    = w_rmw      ? w_merge_data
                           : w_sel_full ? w_sel_wdata
                           : 32'h0;

    assign arb_busy = (state_q == ST_RMW);

    // Port sequencer: a partial write parks here for exactly one cycle while
    // the merged word is written back.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            rmw_addr_q   <= '0;
            rmw_wdata_q  <= 32'h0;
            rmw_byteen_q <= 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_sel_part) begin
                        state_q      <= ST_RMW;
                        rmw_addr_q   <= w_sel_addr;
                        rmw_wdata_q  <= w_sel_wdata;
                        rmw_byteen_q <= w_sel_byteen;
                    end
                end
                ST_RMW: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read response valids, one cycle behind the read grant.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lsu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            lsu_rvalid_q <= w_lsu_win & ~lsu_wr;
            dma_rvalid_q <= w_dma_win & ~dma_wr;
        end
    end

    // Response data: the macro's read data is presented in the rvalid cycle
    // and then held in a register until the next response to that owner.
    assign lsu_rvalid = lsu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign lsu_rdata  = lsu_rvalid_q ? dccm_rd_data_lo : lsu_rdata_q;
    assign dma_rdata  = dma_rvalid_q ? dccm_rd_data_lo : dma_rdata_q;

    // Hold registers for the last delivered read data.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lsu_rdata_q <= 32'h0;
            dma_rdata_q <= 32'h0;
        end else begin
            lsu_rdata_q <= lsu_rdata;
            dma_rdata_q <= dma_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dccm_port_arb.sv
// ============================================================================
// Module      : tb_dccm_port_arb
// Description : Directed self-checking bench for dccm_port_arb with a small
//               synchronous-read DCCM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dccm_port_arb;

    localparam int ADDR_W     = 16;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst_l;
    logic              lsu_req, lsu_wr, dma_req, dma_wr;
    logic [ADDR_W-1:0] lsu_addr, dma_addr;
    logic [31:0]       lsu_wdata, dma_wdata;
    logic [3:0]        lsu_byteen, dma_byteen;
    logic              lsu_gnt, dma_gnt, lsu_rvalid, dma_rvalid;
    logic [31:0]       lsu_rdata, dma_rdata;
    logic              dccm_rden, dccm_wren, arb_busy;
    logic [ADDR_W-1:0] dccm_rd_addr_lo, dccm_wr_addr;
    logic [31:0]       dccm_wr_data;
    logic [31:0]       dccm_rd_data_lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    dccm_port_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .lsu_req         (lsu_req),
        .lsu_wr          (lsu_wr),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_byteen      (lsu_byteen),
        .lsu_gnt         (lsu_gnt),
        .lsu_rvalid      (lsu_rvalid),
        .lsu_rdata       (lsu_rdata),
        .dma_req         (dma_req),
        .dma_wr          (dma_wr),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_byteen      (dma_byteen),
        .dma_gnt         (dma_gnt),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .dccm_rden       (dccm_rden),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_wren       (dccm_wren),
        .dccm_wr_addr    (dccm_wr_addr),
        .dccm_wr_data    (dccm_wr_data),
        .dccm_rd_data_lo (dccm_rd_data_lo),
        .arb_busy        (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DCCM model: synchronous read, data valid the cycle after rden.
    always @(posedge clk) begin
        if (dccm_rden) dccm_rd_data_lo <= mem[dccm_rd_addr_lo[9:2]];
        if (dccm_wren) mem[dccm_wr_addr[9:2]] <= dccm_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_set(input logic req, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        lsu_req = req; lsu_wr = wr; lsu_addr = a; lsu_wdata = d; lsu_byteen = be;
    endtask

    task automatic dma_set(input logic req, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        dma_req = req; dma_wr = wr; dma_addr = a; dma_wdata = d; dma_byteen = be;
    endtask

    initial begin
        dccm_rd_data_lo = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16'h0040 >> 2] = 32'hDEADBEEF;
        mem[16'h0080 >> 2] = 32'h11223344;
        mem[0] = 32'hA0A0A0A0;
        mem[1] = 32'hA1A1A1A1;
        mem[2] = 32'hA2A2A2A2;

        rst_l = 1'b0;
        lsu_set(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
        dma_set(1'b1, 1'b0, 16'h0080, 32'h0, 4'h0);

        // Reset state: registered outputs cleared, combinational outputs gated.
        step();
        #4;
        check("rst_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        check("rst_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);
        check("rst_busy", {31'b0, arb_busy}, 32'd0);
        check("rst_gnts", {30'b0, lsu_gnt, dma_gnt}, 32'd0);
        check("rst_dccm_en", {30'b0, dccm_rden, dccm_wren}, 32'd0);
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        dma_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        step();
        rst_l = 1'b1;
        step();

        // LSU read of 0x0040.
        lsu_set(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
        @(negedge clk);
        check("rd_lsu_gnt", {31'b0, lsu_gnt}, 32'd1);
        check("rd_rden", {31'b0, dccm_rden}, 32'd1);
        check("rd_addr", {16'b0, dccm_rd_addr_lo}, 32'h0040);
        check("rd_no_wren", {31'b0, dccm_wren}, 32'd0);
        step();
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("rd_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd1);
        check("rd_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
        check("rd_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        step();
        check("rd_rvalid_pulse", {31'b0, lsu_rvalid}, 32'd0);

        // DMA partial write, byteen=4'h2, with an LSU read arriving during RMW.
        dma_set(1'b1, 1'b1, 16'h0080, 32'h0000AB00, 4'h2);
        @(negedge clk);
        check("rmw_dma_gnt", {31'b0, dma_gnt}, 32'd1);
        check("rmw_c0_rden", {31'b0, dccm_rden}, 32'd1);
        check("rmw_c0_rdaddr", {16'b0, dccm_rd_addr_lo}, 32'h0080);
        check("rmw_c0_wren", {31'b0, dccm_wren}, 32'd0);
        step();
        dma_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        lsu_set(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
        @(negedge clk);
        check("rmw_c1_wren", {31'b0, dccm_wren}, 32'd1);
        check("rmw_c1_rden", {31'b0, dccm_rden}, 32'd0);
        check("rmw_c1_wdata", dccm_wr_data, 32'h1122AB44);
        check("rmw_c1_waddr", {16'b0, dccm_wr_addr}, 32'h0080);
        check("rmw_c1_busy", {31'b0, arb_busy}, 32'd1);
        check("rmw_c1_gnts", {30'b0, lsu_gnt, dma_gnt}, 32'd0);
        check("rmw_c1_no_rvalid", {30'b0, lsu_rvalid, dma_rvalid}, 32'd0);
        step();
        @(negedge clk);
        check("rmw_c2_lsu_gnt", {31'b0, lsu_gnt}, 32'd1);
        check("rmw_c2_busy", {31'b0, arb_busy}, 32'd0);
        check("rmw_mem", mem[16'h0080 >> 2], 32'h1122AB44);
        step();
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("rmw_c3_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
        step();

        // LSU write with no byte enables: accepted, no DCCM access.
        lsu_set(1'b1, 1'b1, 16'h0040, 32'h55555555, 4'h0);
        @(negedge clk);
        check("be0_gnt", {31'b0, lsu_gnt}, 32'd1);
        check("be0_dccm_en", {30'b0, dccm_rden, dccm_wren}, 32'd0);
        step();
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("be0_busy", {31'b0, arb_busy}, 32'd0);
        check("be0_no_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        step();

        // Full-word write to 0x000C.
        lsu_set(1'b1, 1'b1, 16'h000C, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        check("full_gnt", {31'b0, lsu_gnt}, 32'd1);
        check("full_wren", {30'b0, dccm_rden, dccm_wren}, 32'd1);
        check("full_waddr", {16'b0, dccm_wr_addr}, 32'h000C);
        check("full_wdata", dccm_wr_data, 32'hCAFEF00D);
        step();
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("full_busy", {31'b0, arb_busy}, 32'd0);
        step();

        // Four back-to-back LSU reads at 0x0, 0x4, 0x8, 0xC.
        begin
            logic [31:0] exp_rd [0:3];
            exp_rd[0] = 32'hA0A0A0A0;
            exp_rd[1] = 32'hA1A1A1A1;
            exp_rd[2] = 32'hA2A2A2A2;
            exp_rd[3] = 32'hCAFEF00D;
            for (int i = 0; i < 5; i++) begin
                if (i < 4) lsu_set(1'b1, 1'b0, 16'(4 * i), 32'h0, 4'h0);
                else       lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
                @(negedge clk);
                check($sformatf("b2b_gnt%0d", i), {31'b0, lsu_gnt}, {31'b0, i < 4});
                if (i < 4) check($sformatf("b2b_addr%0d", i), {16'b0, dccm_rd_addr_lo}, 32'(4 * i));
                check($sformatf("b2b_rvalid%0d", i), {31'b0, lsu_rvalid}, {31'b0, i > 0});
                if (i > 0) check($sformatf("b2b_rdata%0d", i), lsu_rdata, exp_rd[i-1]);
                step();
            end
        end

        // Both requesters present continuously.
        lsu_set(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0);
        dma_set(1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
        for (int c = 0; c < 10; c++) begin
            logic exp_dma;
`ifdef RV_DCCM_ARB_STARVE_EN
            exp_dma = ((c % (STARVE_MAX + 1)) == STARVE_MAX);
`else
            exp_dma = 1'b0;
`endif
            @(negedge clk);
            check($sformatf("arb_c%0d", c), {30'b0, lsu_gnt, dma_gnt}, {30'b0, ~exp_dma, exp_dma});
            step();
        end
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        dma_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        step();

        // Reset asserted during the RMW cycle abandons the write.
        lsu_set(1'b1, 1'b1, 16'h0040, 32'h000000FF, 4'h1);
        @(negedge clk);
        check("rrst_c0_rden", {31'b0, dccm_rden}, 32'd1);
        step();
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        #1;
        check("rrst_c1_wren", {31'b0, dccm_wren}, 32'd1);
        check("rrst_c1_busy", {31'b0, arb_busy}, 32'd1);
        rst_l = 1'b0;
        #1;
        check("rrst_wren_off", {31'b0, dccm_wren}, 32'd0);
        check("rrst_busy_off", {31'b0, arb_busy}, 32'd0);
        check("rrst_rvalids", {30'b0, lsu_rvalid, dma_rvalid}, 32'd0);
        step();
        check("rrst_mem_intact", mem[16'h0040 >> 2], 32'hDEADBEEF);
        rst_l = 1'b1;
        step();
        lsu_set(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
        @(negedge clk);
        check("rrst_post_gnt", {31'b0, lsu_gnt}, 32'd1);
        step();
        lsu_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("rrst_post_rdata", lsu_rdata, 32'hDEADBEEF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
